// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment code type, blank code and hex glyph table.
package seg7_pkg;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_BLANK = 7'h00;

  // Active-high {A,B,C,D,E,F,G}, A at bit 6, indexed by hex value 0..F.
  localparam seg_code_t SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_code_t  o_seg
);

  always_comb o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed seven-segment driver with blanking dead time and frame-synchronous value commit.
// Optional macro SEG7_LZ_SUPPRESS_EN blanks leading zero digits (digit 0 always shown).
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 2500,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] Value,
  output logic                    Ready,
  output logic [6:0]              Segment,
  output logic [NUM_DIGITS-1:0]   Digit_En,
  output logic                    Frame_Done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_C   = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_display;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;
  seg_code_t               r_segment;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic                    r_frame_done;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic                    w_dead;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_lz_blank;
  seg_code_t               w_code;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_dead      = (r_cnt < DEAD_C);

  always_comb begin
    w_nibble = '0;
    w_onehot = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (r_idx == IDX_W'(d)) begin
        w_nibble    = r_display[4*d +: 4];
        w_onehot[d] = 1'b1;
      end
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  logic w_upper_zero;

  // Blank when this digit and every digit above it are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if ((IDX_W'(d) >= r_idx) && (r_display[4*d +: 4] != 4'h0)) w_upper_zero = 1'b0;
    end
    w_lz_blank = w_upper_zero && (r_idx != '0);
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  seg7_encode u_encode (
    .i_nibble (w_nibble),
    .o_seg    (w_code)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_display    <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_segment    <= SEG_BLANK;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_slot_end) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      r_frame_done <= w_frame_end;

      // Acceptance needs !pending, so a frame-end Load waits for the next frame end.
      if (Load && !r_pending) begin
        r_shadow  <= Value;
        r_pending <= 1'b1;
      end else if (w_frame_end && r_pending) begin
        r_display <= r_shadow;
        r_pending <= 1'b0;
      end

      r_segment  <= (w_dead || w_lz_blank) ? SEG_BLANK : w_code;
      r_digit_en <= w_dead ? '0 : w_onehot;
    end
  end

  assign Ready      = !r_pending;
  assign Segment    = r_segment;
  assign Digit_En   = r_digit_en;
  assign Frame_Done = r_frame_done;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver: cycle scoreboard plus per-frame digit pattern table.
module tb_seg7_mux_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FRAME = ND * RD;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        Load = 1'b0;
  logic [15:0] Value = '0;
  logic        Ready;
  logic [6:0]  Segment;
  logic [3:0]  Digit_En;
  logic        Frame_Done;

  always #5 CLK = ~CLK;

  seg7_mux_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Load       (Load),
    .Value      (Value),
    .Ready      (Ready),
    .Segment    (Segment),
    .Digit_En   (Digit_En),
    .Frame_Done (Frame_Done)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] en;
    logic       fd;
    logic       rdy;
  } exp_t;

  typedef struct packed {
    logic [15:0]     val;
    logic [3:0][6:0] seg;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;

  int          m_cnt, m_idx;
  logic [15:0] m_disp, m_shadow;
  logic        m_ready;
  logic [7:0]  seen[4];

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
      4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
      4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input logic [15:0] disp, input int idx);
    logic [15:0] up;
    up = disp >> (4 * idx);
`ifdef SEG7_LZ_SUPPRESS_EN
    if (idx != 0 && up == 16'h0) return 7'h00;
`endif
    return enc(up[3:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_disp = '0; m_shadow = '0; m_ready = 1'b1;
  endtask

  task automatic tick(input logic ld, input logic [15:0] val);
    exp_t e, g;
    logic fe;
    Load  = ld;
    Value = val;
    fe    = (m_idx == ND - 1) && (m_cnt == RD - 1);
    e.seg = (m_cnt < DC) ? 7'h00 : model_seg(m_disp, m_idx);
    e.en  = (m_cnt < DC) ? 4'b0000 : 4'(1 << m_idx);
    e.fd  = fe;
    if (ld && m_ready) begin
      m_shadow = val;
      m_ready  = 1'b0;
    end else if (fe && !m_ready) begin
      m_disp  = m_shadow;
      m_ready = 1'b1;
    end
    e.rdy = m_ready;
    if (m_cnt == RD - 1) begin
      m_cnt = 0;
      m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
    end else begin
      m_cnt++;
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    check("segment", Segment, g.seg);
    check("digit_en", Digit_En, g.en);
    check("frame_done", Frame_Done, g.fd);
    check("ready", Ready, g.rdy);
    check("onehot_blank", $onehot0(Digit_En) && (Digit_En != 0 || Segment == 7'h00), 1);
    for (int d = 0; d < 4; d++) if (Digit_En[d]) seen[d] = {1'b0, Segment};
    Load  = 1'b0;
  endtask

  task automatic reset_now();
    Load  = 1'b0;
    RST_N = 1'b0;
    #1;
    check("rst_segment", Segment, 7'h00);
    check("rst_digit_en", Digit_En, 4'b0000);
    check("rst_frame_done", Frame_Done, 1'b0);
    check("rst_ready", Ready, 1'b1);
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic capture_frame(input string name, input vec_t v);
    for (int d = 0; d < 4; d++) seen[d] = 8'hFF;
    repeat (FRAME) tick(1'b0, 16'h0);
    for (int d = 0; d < 4; d++) check(name, seen[d], {1'b0, v.seg[d]});
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!Ready && n < 2 * FRAME) begin tick(1'b0, 16'h0); n++; end
    if (!Ready) check("ready_timeout", Ready, 1'b1);
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    do begin tick(1'b0, 16'h0); n++; end while (!Frame_Done && n < FRAME + 8);
    check("frame_done_seen", Frame_Done, 1'b1);
  endtask

  task automatic set_vec(input int i, input logic [15:0] val,
                         input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
    vecs[i].val    = val;
    vecs[i].seg[0] = s0;
    vecs[i].seg[1] = s1;
    vecs[i].seg[2] = s2;
    vecs[i].seg[3] = s3;
  endtask

  initial begin
    int fdcount;
    int n;
    set_vec(0, 16'h1234, 7'h33, 7'h79, 7'h6D, 7'h30);
`ifdef SEG7_LZ_SUPPRESS_EN
    set_vec(1, 16'h0050, 7'h7E, 7'h5B, 7'h00, 7'h00);
    set_vec(2, 16'h0000, 7'h7E, 7'h00, 7'h00, 7'h00);
`else
    set_vec(1, 16'h0050, 7'h7E, 7'h5B, 7'h7E, 7'h7E);
    set_vec(2, 16'h0000, 7'h7E, 7'h7E, 7'h7E, 7'h7E);
`endif
    set_vec(3, 16'hF00D, 7'h3D, 7'h7E, 7'h7E, 7'h47);
    set_vec(4, 16'hABCD, 7'h3D, 7'h4E, 7'h1F, 7'h77);

    #2;
    reset_now();

    // Idle after reset: two frames, Frame_Done once per frame, zero display.
    fdcount = 0;
    for (int d = 0; d < 4; d++) seen[d] = 8'hFF;
    repeat (2 * FRAME) begin
      tick(1'b0, 16'h0);
      if (Frame_Done) fdcount++;
    end
    check("frame_done_count", fdcount, 2);
    for (int d = 0; d < 4; d++) check("idle_digit", seen[d], {1'b0, vecs[2].seg[d]});

    // Mid-frame loads; the first is followed by an ignored load while busy.
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      repeat (5) tick(1'b0, 16'h0);
      tick(1'b1, vecs[i].val);
      check("ready_after_load", Ready, 1'b0);
      if (i == 0) tick(1'b1, 16'hFFFF);
      wait_frame_done();
      check("ready_at_commit", Ready, 1'b1);
      capture_frame("table_digit", vecs[i]);
    end

    // Load exactly on the frame-end cycle commits one frame later.
    n = 0;
    while (!((m_idx == ND - 1) && (m_cnt == RD - 1)) && n < FRAME + 8) begin
      tick(1'b0, 16'h0);
      n++;
    end
    check("frame_end_reached", Ready, 1'b1);
    tick(1'b1, vecs[4].val);
    capture_frame("fe_load_old", vecs[3]);
    capture_frame("fe_load_new", vecs[4]);

    // Reset mid-slot with a pending value discards it.
    wait_ready();
    repeat (3) tick(1'b0, 16'h0);
    tick(1'b1, 16'h5A5A);
    repeat (3) tick(1'b0, 16'h0);
    #2;
    reset_now();
    check("ready_after_reset", Ready, 1'b1);
    capture_frame("post_reset_frame1", vecs[2]);
    capture_frame("post_reset_frame2", vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 2500, clock cycles per digit slot (>= DEAD_CYCLES+2).
REQ-003 SHALL have parameter DEAD_CYCLES, default 2, all-digits-off cycles at the start of each slot (anti-ghosting).
REQ-004 SHALL have port CLK, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port Load, input, 1, request to accept Value.
REQ-007 SHALL have port Value, input, 4*NUM_DIGITS, hex nibbles; nibble 0 (bits 3:0) = digit 0, the rightmost digit.
REQ-008 SHALL have port Ready, output, 1, high when a Load will be accepted.
REQ-009 SHALL have port Segment, output, 7, active-high segments {A,B,C,D,E,F,G}, with A at bit 6.
REQ-010 SHALL have port Digit_En, output, NUM_DIGITS, one-hot active-high digit select, or all zero.
REQ-011 SHALL have port Frame_Done, output, 1, one-cycle pulse at each frame end.

Function
REQ-012 SHALL keep slot counter cnt (0..REFRESH_DIV-1) and digit index idx (0..NUM_DIGITS-1).
REQ-013 cnt SHALL increment every cycle; at REFRESH_DIV-1 it SHALL wrap to 0 and idx SHALL advance, wrapping NUM_DIGITS-1 -> 0.
REQ-014 Segment and Digit_En SHALL be registered, reflecting the (idx,cnt) of the previous cycle: exactly 1 cycle latency.
REQ-015 While cnt < DEAD_CYCLES: Digit_En=0 and Segment=7'h00; otherwise Digit_En[idx]=1 and Segment=encode(display nibble idx).
REQ-016 encode SHALL map hex 0..F to 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47.
REQ-017 Handshake: Load=1 while Ready=1 SHALL capture Value into shadow, set pending, and drive Ready=0 from the next cycle.
REQ-018 Load while Ready=0 SHALL be ignored; the shadow SHALL NOT change.
REQ-019 Frame end = cycle with idx=NUM_DIGITS-1 and cnt=REFRESH_DIV-1; Frame_Done SHALL be 1 the following cycle only.
REQ-020 At frame end with pending=1: display<=shadow, pending<=0, Ready<=1. With pending=0: display SHALL be unchanged (no mid-frame tearing).
REQ-021 Load accepted on the frame-end cycle itself SHALL commit at the next frame end, not the current one.
REQ-022 Only digits with Digit_En high SHALL ever see non-zero Segment; Digit_En SHALL never have more than one bit set.

Reset
REQ-023 RST_N low SHALL immediately force cnt=0, idx=0, display=0, shadow=0, pending=0, Ready=1, Segment=7'h00, Digit_En=0, Frame_Done=0.
REQ-024 A reset mid-frame or with a pending load SHALL discard the pending value; after release the first slot SHALL begin with digit 0 and DEAD_CYCLES blank cycles.

Configuration
REQ-025 Macro SEG7_LZ_SUPPRESS_EN, when defined, SHALL blank (Segment=7'h00, Digit_En still asserted) every zero digit above the most significant non-zero digit; digit 0 SHALL always display.
REQ-026 Without SEG7_LZ_SUPPRESS_EN, all digits SHALL display, including leading zeros.

Structure
REQ-027 Shared package seg7_pkg SHALL hold the 16-entry encoding constant table, SEG_BLANK=7'h00, and the seg_code_t 7-bit typedef.
REQ-028 Encoding SHALL live in combinational sub-module seg7_encode (4-bit in, 7-bit out), instantiated once on the muxed nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2; frame = 32 cycles)
REQ-029 Reset release, no load -> per slot: 2 cycles Digit_En=0, then 6 cycles Digit_En=0001/0010/0100/1000 in turn, Segment=7E; Frame_Done every 32 cycles.
REQ-030 Load Value=16'h1234 mid-frame -> Ready=0 next cycle; display unchanged until frame end; following frame shows digit0=4 (33), digit1=3 (79), digit2=2 (6D), digit3=1 (30); Ready=1 with Frame_Done.
REQ-031 Second Load=16'hFFFF while Ready=0 -> ignored; 16'h1234 still shown after commit.
REQ-032 Load 16'hABCD on the frame-end cycle -> not shown in the next frame; shown (digit0=3D, digit1=4E, digit2=1F, digit3=77) one frame later.
REQ-033 RST_N pulsed low mid-slot with a pending load -> outputs zero immediately; after release, display=0000 and Ready=1.
REQ-034 With SEG7_LZ_SUPPRESS_EN defined, Value=16'h0050 -> digit3 and digit2 Segment=00, digit1=5B, digit0=7E; Value=16'h0000 -> only digit0 shows 7E.
